// File: rtl/neural_layer_backprop_seq.sv
// Sequential backward pass of one fully connected float32 layer: delta, weight/bias
// gradients and input gradient, computed on one multiply-add path plus one multiplier.

module fp_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic        sgn;
  logic [7:0]  ea, eb;
  logic [47:0] prod;
  logic [23:0] mant;
  logic        rb, st;
  logic [24:0] rnd;
  logic [22:0] frac;
  int          ex;

  always_comb begin
    sgn  = a[31] ^ b[31];
    ea   = a[30:23];
    eb   = b[30:23];
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    ex   = int'(ea) + int'(eb) - 127;
    if (prod[47]) begin
      mant = prod[47:24];
      rb   = prod[23];
      st   = |prod[22:0];
      ex   = ex + 1;
    end else begin
      mant = prod[46:23];
      rb   = prod[22];
      st   = |prod[21:0];
    end
    // Round to nearest, ties to even.
    rnd  = {1'b0, mant} + 25'(rb & (st | mant[0]));
    frac = rnd[24] ? rnd[23:1] : rnd[22:0];
    if (rnd[24]) ex = ex + 1;
    y = '0;
    if ((ea == 8'hFF && a[22:0] != '0) || (eb == 8'hFF && b[22:0] != '0)) y = 32'h7FC00000;
    else if (ea == 8'hFF || eb == 8'hFF) y = (ea == 8'h00 || eb == 8'h00) ? 32'h7FC00000 : {sgn, 8'hFF, 23'b0};
    else if (ea == 8'h00 || eb == 8'h00) y = {sgn, 31'b0};
    else if (ex >= 255) y = {sgn, 8'hFF, 23'b0};
    else if (ex <= 0) y = {sgn, 31'b0};
    else y = {sgn, ex[7:0], frac};
  end
endmodule

module fp_add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0] big, sml;
  logic [26:0] mb, ms, ms_sh, mask, norm;
  logic [27:0] sum;
  logic [7:0]  d;
  logic        sticky, inc;
  logic [24:0] rnd;
  logic [22:0] frac;
  int          ex, lz;

  always_comb begin
    if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    // Three extra low bits carry guard, round and sticky through alignment.
    mb     = {1'b1, big[22:0], 3'b000};
    ms     = {1'b1, sml[22:0], 3'b000};
    d      = big[30:23] - sml[30:23];
    mask   = '0;
    ms_sh  = '0;
    sticky = 1'b1;
    if (d < 8'd27) begin
      mask   = (27'd1 << d) - 27'd1;
      ms_sh  = ms >> d;
      sticky = |(ms & mask);
    end
    ms_sh[0] = ms_sh[0] | sticky;
    sum = (big[31] == sml[31]) ? {1'b0, mb} + {1'b0, ms_sh} : {1'b0, mb} - {1'b0, ms_sh};
    lz = 0;
    for (int k = 0; k < 27; k++) if (sum[k]) lz = 26 - k;
    ex = int'(big[30:23]);
    if (sum[27]) begin
      norm = {sum[27:2], sum[1] | sum[0]};
      ex   = ex + 1;
    end else begin
      norm = sum[26:0] << lz;
      ex   = ex - lz;
    end
    inc  = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd  = {1'b0, norm[26:3]} + 25'(inc);
    frac = rnd[24] ? rnd[23:1] : rnd[22:0];
    if (rnd[24]) ex = ex + 1;
    y = '0;
    if (big[30:23] == 8'hFF) begin
      if (big[22:0] != '0) y = 32'h7FC00000;
      else if (sml[30:23] == 8'hFF && big[31] != sml[31]) y = 32'h7FC00000;
      else y = big;
    end
    else if (big[30:23] == 8'h00) y = {big[31] & sml[31], 31'b0};
    else if (sml[30:23] == 8'h00) y = big;
    else if (sum == '0) y = '0;
    else if (ex >= 255) y = {big[31], 8'hFF, 23'b0};
    else if (ex <= 0) y = {big[31], 31'b0};
    else y = {big[31], ex[7:0], frac};
  end
endmodule

module neural_layer_backprop_seq #(
  parameter int IN_SIZE    = 1,
  parameter int OUT_SIZE   = 1,
  parameter int ACTIVATION = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [32*OUT_SIZE-1:0]          pre_act,
  input  logic [32*OUT_SIZE-1:0]          act_out,
  input  logic [32*OUT_SIZE-1:0]          grad_out,
  input  logic [32*IN_SIZE-1:0]           data,
  input  logic [32*OUT_SIZE*IN_SIZE-1:0]  weights,
  output logic [32*IN_SIZE-1:0]           grad_in,
  output logic [32*OUT_SIZE*IN_SIZE-1:0]  grad_weights,
  output logic [32*OUT_SIZE-1:0]          grad_bias,
  output logic                            busy,
  output logic                            done,
  output logic [1:0]                      fsm_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, DELTA = 2'd1, ACCUM = 2'd2, DONE = 2'd3} state_t;

  localparam int          IW       = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int          OW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic        TWO_STEP = (ACTIVATION == 1) || (ACTIVATION == 3);
  localparam logic [31:0] FP_ONE   = 32'h3F800000;

  state_t      state, state_nx;
  logic        start_q;
  logic [OW-1:0] i_cnt;
  logic [IW-1:0] j_cnt;
  logic        phase;
  logic [31:0] s_reg;
  logic        last_i, last_j;
  logic [31:0] z_i, y_i, g_i, d_i, x_j, w_ij, gin_j;
  logic [31:0] mul0_a, mul0_b, mul0_y, mul1_y, add_a, add_b, add_y, delta_val;

  // Handshake: start is a level, captured on any edge after which the block is idle
  // and acted on one edge later; done is a one-cycle pulse. Inputs stay stable from
  // start until done because nothing here latches them.
  assign last_i    = (int'(i_cnt) == OUT_SIZE - 1);
  assign last_j    = (int'(j_cnt) == IN_SIZE - 1);
  assign busy      = (state == DELTA) || (state == ACCUM);
  assign done      = (state == DONE);
  assign fsm_state = state;

  always_comb begin
    z_i   = pre_act[32*int'(i_cnt) +: 32];
    y_i   = act_out[32*int'(i_cnt) +: 32];
    g_i   = grad_out[32*int'(i_cnt) +: 32];
    d_i   = grad_bias[32*int'(i_cnt) +: 32];
    x_j   = data[32*int'(j_cnt) +: 32];
    gin_j = grad_in[32*int'(j_cnt) +: 32];
    w_ij  = weights[32*(int'(i_cnt)*IN_SIZE + int'(j_cnt)) +: 32];
  end

  always_comb begin
    mul0_a = w_ij;
    mul0_b = d_i;
    if (state == DELTA) begin
      if (!phase) begin
        mul0_a = y_i;
        mul0_b = y_i;
      end else begin
        mul0_a = g_i;
        mul0_b = s_reg;
      end
    end
  end

  // In DELTA the adder forms y - y*y (sigmoid) or 1 - y*y (tanh) from the negated square.
  always_comb begin
    add_a     = gin_j;
    add_b     = mul0_y;
    delta_val = g_i;
    if (state == DELTA) begin
      add_a = (ACTIVATION == 1) ? y_i : FP_ONE;
      add_b = {~mul0_y[31], mul0_y[30:0]};
      if (TWO_STEP) delta_val = mul0_y;
      else if (ACTIVATION == 0) delta_val = (!z_i[31] && (z_i[30:0] != '0)) ? g_i : '0;
    end
  end

  fp_mul u_mul0 (.a(mul0_a), .b(mul0_b), .y(mul0_y));
  fp_mul u_mul1 (.a(d_i), .b(x_j), .y(mul1_y));
  fp_add u_add  (.a(add_a), .b(add_b), .y(add_y));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_q) state_nx = DELTA;
      DELTA:   if (last_i && (!TWO_STEP || phase)) state_nx = ACCUM;
      ACCUM:   if (last_i && last_j) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q      <= 1'b0;
      i_cnt        <= '0;
      j_cnt        <= '0;
      phase        <= 1'b0;
      s_reg        <= '0;
      grad_in      <= '0;
      grad_weights <= '0;
      grad_bias    <= '0;
    end else begin
      start_q <= start && (state_nx == IDLE);
      case (state)
        IDLE: begin
          if (start_q) begin
            i_cnt   <= '0;
            j_cnt   <= '0;
            phase   <= 1'b0;
            grad_in <= '0;
          end
        end
        DELTA: begin
          if (TWO_STEP && !phase) begin
            s_reg <= add_y;
            phase <= 1'b1;
          end else begin
            grad_bias[32*int'(i_cnt) +: 32] <= delta_val;
            phase <= 1'b0;
            i_cnt <= last_i ? '0 : i_cnt + 1'b1;
          end
        end
        ACCUM: begin
          grad_weights[32*(int'(i_cnt)*IN_SIZE + int'(j_cnt)) +: 32] <= mul1_y;
          grad_in[32*int'(j_cnt) +: 32] <= add_y;
          if (last_j) begin
            j_cnt <= '0;
            i_cnt <= last_i ? '0 : i_cnt + 1'b1;
          end else begin
            j_cnt <= j_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_neural_layer_backprop_seq.sv
// Directed bench: a 2x2 ReLU layer plus 1x1 sigmoid, tanh and identity layers.

module tb_neural_layer_backprop_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         r_start;
  logic [63:0]  r_z, r_y, r_g, r_x, r_gi, r_gb;
  logic [127:0] r_w, r_gw;
  logic         r_busy, r_done;
  logic [1:0]   r_state;

  neural_layer_backprop_seq #(.IN_SIZE(2), .OUT_SIZE(2), .ACTIVATION(0)) u_relu (
    .clk(clk), .rst(rst), .start(r_start), .pre_act(r_z), .act_out(r_y), .grad_out(r_g),
    .data(r_x), .weights(r_w), .grad_in(r_gi), .grad_weights(r_gw), .grad_bias(r_gb),
    .busy(r_busy), .done(r_done), .fsm_state(r_state)
  );

  logic        o_start[3];
  logic [31:0] o_z[3], o_y[3], o_g[3], o_x[3], o_w[3], o_gi[3], o_gw[3], o_gb[3];
  logic        o_busy[3], o_done[3];
  logic [1:0]  o_state[3];

  // Instance 0 sigmoid, 1 tanh, 2 identity.
  for (genvar k = 0; k < 3; k++) begin : g_one
    neural_layer_backprop_seq #(.IN_SIZE(1), .OUT_SIZE(1),
                                .ACTIVATION((k == 0) ? 1 : ((k == 1) ? 3 : 2))) u_one (
      .clk(clk), .rst(rst), .start(o_start[k]), .pre_act(o_z[k]), .act_out(o_y[k]),
      .grad_out(o_g[k]), .data(o_x[k]), .weights(o_w[k]), .grad_in(o_gi[k]),
      .grad_weights(o_gw[k]), .grad_bias(o_gb[k]), .busy(o_busy[k]), .done(o_done[k]),
      .fsm_state(o_state[k])
    );
  end

  typedef struct {
    logic [63:0]  z, g, x;
    logic [127:0] w;
    logic [63:0]  gb;
    logic [127:0] gw;
    logic [63:0]  gi;
  } relu_vec_t;

  typedef struct {
    logic [31:0] z, y, g, x, w, gb, gw, gi;
    int          done_edge;
  } one_vec_t;

  relu_vec_t    rv[4];
  one_vec_t     ov[3];
  logic [127:0] exp_q[$];
  int           tests = 0;
  int           fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_q(input string name, input logic [127:0] act);
    logic [127:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got %0h with no expected value queued", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  task automatic set_relu(input int r);
    r_z = rv[r].z;
    r_y = '0;
    r_g = rv[r].g;
    r_x = rv[r].x;
    r_w = rv[r].w;
  endtask

  // Called at a negedge with the layer idle; start is sampled at the next edge (edge 0).
  task automatic relu_pass(input int r);
    int de, bc;
    set_relu(r);
    exp_q.push_back(128'(rv[r].gb));
    exp_q.push_back(rv[r].gw);
    exp_q.push_back(128'(rv[r].gi));
    r_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r_start = 1'b0;
    de = -1;
    bc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (r_busy) bc++;
      if (r_done) begin
        de = k;
        break;
      end
    end
    check($sformatf("relu%0d_done_edge", r), 128'(de), 128'd7);
    check($sformatf("relu%0d_busy_cycles", r), 128'(bc), 128'd6);
    check_q($sformatf("relu%0d_grad_bias", r), 128'(r_gb));
    check_q($sformatf("relu%0d_grad_weights", r), r_gw);
    check_q($sformatf("relu%0d_grad_in", r), 128'(r_gi));
    @(posedge clk);
    @(negedge clk);
    check($sformatf("relu%0d_idle_after", r), 128'(r_state), 128'd0);
  endtask

  task automatic one_pass(input int k);
    int de, bc;
    o_z[k] = ov[k].z;
    o_y[k] = ov[k].y;
    o_g[k] = ov[k].g;
    o_x[k] = ov[k].x;
    o_w[k] = ov[k].w;
    exp_q.push_back(128'(ov[k].gb));
    exp_q.push_back(128'(ov[k].gw));
    exp_q.push_back(128'(ov[k].gi));
    o_start[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o_start[k] = 1'b0;
    de = -1;
    bc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (o_busy[k]) bc++;
      if (o_done[k]) begin
        de = c;
        break;
      end
    end
    check($sformatf("one%0d_done_edge", k), 128'(de), 128'(ov[k].done_edge));
    check($sformatf("one%0d_busy_cycles", k), 128'(bc), 128'(ov[k].done_edge - 1));
    check_q($sformatf("one%0d_grad_bias", k), 128'(o_gb[k]));
    check_q($sformatf("one%0d_grad_weights", k), 128'(o_gw[k]));
    check_q($sformatf("one%0d_grad_in", k), 128'(o_gi[k]));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_done, second_done, extra_done;

    // ReLU 2x2 vectors, element 0 in the low word; w/gw order {W11, W10, W01, W00}.
    rv[0].z  = {32'hC0000000, 32'h3F800000};
    rv[0].g  = {32'h40400000, 32'h3F000000};
    rv[0].x  = {32'h40800000, 32'h40000000};
    rv[0].w  = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    rv[0].gb = {32'h00000000, 32'h3F000000};
    rv[0].gw = {32'h00000000, 32'h00000000, 32'h40000000, 32'h3F800000};
    rv[0].gi = {32'h3F800000, 32'h3F000000};
    // z0 = -0.0 must gate its row off entirely.
    rv[1].z  = {32'h3F800000, 32'h80000000};
    rv[1].g  = {32'h3F000000, 32'h40A00000};
    rv[1].x  = {32'h40800000, 32'h40000000};
    rv[1].w  = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    rv[1].gb = {32'h3F000000, 32'h00000000};
    rv[1].gw = {32'h40000000, 32'h3F800000, 32'h00000000, 32'h00000000};
    rv[1].gi = {32'h40000000, 32'h3FC00000};
    // z1 = +0.0, negative gradients, a -0 weight gradient.
    rv[2].z  = {32'h00000000, 32'h40400000};
    rv[2].g  = {32'h40000000, 32'hBF800000};
    rv[2].x  = {32'hC0000000, 32'h3F800000};
    rv[2].w  = {32'h3F800000, 32'h3F800000, 32'h3E800000, 32'h3F000000};
    rv[2].gb = {32'h00000000, 32'hBF800000};
    rv[2].gw = {32'h80000000, 32'h00000000, 32'h40000000, 32'hBF800000};
    rv[2].gi = {32'hBE800000, 32'hBF000000};
    // 3 + (-2.5) cancels and renormalises; 1 + 0.75 aligns.
    rv[3].z  = {32'h3F800000, 32'h3F800000};
    rv[3].g  = {32'h3F800000, 32'h3F800000};
    rv[3].x  = {32'h3F800000, 32'h3F800000};
    rv[3].w  = {32'h3F400000, 32'hC0200000, 32'h3F800000, 32'h40400000};
    rv[3].gb = {32'h3F800000, 32'h3F800000};
    rv[3].gw = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    rv[3].gi = {32'h3FE00000, 32'h3F000000};

    ov[0] = '{z: 32'h0, y: 32'h3F000000, g: 32'h3F800000, x: 32'h40000000, w: 32'h40400000,
              gb: 32'h3E800000, gw: 32'h3F000000, gi: 32'h3F400000, done_edge: 4};
    ov[1] = '{z: 32'h0, y: 32'h3F000000, g: 32'h40000000, x: 32'h3F800000, w: 32'h3F800000,
              gb: 32'h3FC00000, gw: 32'h3FC00000, gi: 32'h3FC00000, done_edge: 4};
    ov[2] = '{z: 32'h0, y: 32'h0, g: 32'hBFC00000, x: 32'h40000000, w: 32'h3F000000,
              gb: 32'hBFC00000, gw: 32'hC0400000, gi: 32'hBF400000, done_edge: 3};

    // Clock/reset.
    rst = 1'b1;
    r_start = 1'b0;
    set_relu(0);
    for (int k = 0; k < 3; k++) begin
      o_start[k] = 1'b0;
      o_z[k] = '0; o_y[k] = '0; o_g[k] = '0; o_x[k] = '0; o_w[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_grad_in", 128'(r_gi), 128'd0);
    check("reset_grad_weights", r_gw, 128'd0);
    check("reset_grad_bias", 128'(r_gb), 128'd0);
    check("reset_busy_done", 128'({r_busy, r_done}), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 4; r++) relu_pass(r);
    for (int k = 0; k < 3; k++) one_pass(k);

    // Reset at edge 4 of the first ReLU case, which is inside ACCUM.
    set_relu(0);
    r_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r_start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midreset_pre_state_accum", 128'(r_state), 128'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midreset_grad_in", 128'(r_gi), 128'd0);
    check("midreset_grad_weights", r_gw, 128'd0);
    check("midreset_grad_bias", 128'(r_gb), 128'd0);
    check("midreset_busy_done", 128'({r_busy, r_done}), 128'd0);
    extra_done = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (r_done) extra_done++;
    end
    check("midreset_no_done", 128'(extra_done), 128'd0);
    relu_pass(0);

    // start held high: one done at edge 7, the second pass is taken at edge 8.
    set_relu(3);
    exp_q.push_back(128'(rv[3].gi));
    exp_q.push_back(128'(rv[3].gi));
    first_done = -1;
    second_done = -1;
    r_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (r_done) begin
        if (first_done < 0) begin
          first_done = k;
          check_q("held_first_grad_in", 128'(r_gi));
        end else begin
          second_done = k;
          r_start = 1'b0;
          check_q("held_second_grad_in", 128'(r_gi));
          break;
        end
      end
    end
    r_start = 1'b0;
    check("held_first_done_edge", 128'(first_done), 128'd7);
    check("held_second_done_edge", 128'(second_done), 128'd15);
    extra_done = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (r_done || r_busy) extra_done++;
    end
    check("held_no_third_pass", 128'(extra_done), 128'd0);
    check("exp_q_drained", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/neural_layer_backprop_seq.md
# neural_layer_backprop_seq

Sequential backward pass for one fully connected layer; counterpart of the sequential forward layer. Given the layer's forward quantities and the loss gradient at its output, it computes the activation-masked error (delta), the weight and bias gradients, and the gradient propagated to the previous layer. All values are IEEE-754 single precision. Arithmetic is time-multiplexed over the team's combinational float multiplier and adder cores, so gradients for any layer size come out of a small, fixed datapath.

## Interface
- IN_SIZE, 1, number of layer inputs (J).
- OUT_SIZE, 1, number of layer outputs (I).
- ACTIVATION, 0, same encoding as the forward layer:
  - 0 ReLU.
  - 1 sigmoid.
  - 3 tanh.
  - Any other value: identity derivative (delta = grad_out).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a pass; sampled only in IDLE.
- pre_act  in  32*OUT_SIZE  forward pre-activation z[i]; used by ReLU.
- act_out  in  32*OUT_SIZE  forward activation y[i]; used by sigmoid and tanh.
- grad_out  in  32*OUT_SIZE  dL/dy[i].
- data  in  32*IN_SIZE  forward input x[j].
- weights  in  32*OUT_SIZE*IN_SIZE  W[i][j] at bits 32*(i*IN_SIZE+j) +: 32.
- grad_in  out  32*IN_SIZE  dL/dx[j], registered.
- grad_weights  out  32*OUT_SIZE*IN_SIZE  dL/dW[i][j]; same layout as weights; registered.
- grad_bias  out  32*OUT_SIZE  delta[i], registered.
- busy  out  1  high in DELTA and ACCUM.
- done  out  1  one-cycle pulse in DONE.

## Operation
- State machine: IDLE -> DELTA -> ACCUM -> DONE -> IDLE.
- IDLE with start=1:
  - Clear i/j counters and the step counter.
  - Clear grad_in accumulators to +0.
  - Go to DELTA.
  - Other outputs keep their previous values until overwritten.
- DELTA, per i ascending:
  - ReLU: 1 cycle. delta = g[i] if z[i] sign=0 and z[i] is not ±0; else +0.
  - Identity: 1 cycle. delta = g[i].
  - Sigmoid: 2 cycles. Step A: s = y - y*y, registered. Step B: delta = g*s.
  - Tanh: 2 cycles. Step A: s = 1.0 - y*y, registered. Step B: delta = g*s.
  - delta[i] is written into grad_bias[i].
  - After the last i, go to ACCUM.
- ACCUM: one (i,j) pair per cycle; i outer, j inner, both ascending.
  - grad_weights[i][j] = delta[i] * x[j].
  - grad_in[j] = grad_in[j] + W[i][j] * delta[i].
  - This gives a fixed summation order, so the result must be bit-exact against a sequential software model using the same order.
  - After (I-1, J-1), go to DONE.
- DONE: done=1 for one cycle, then IDLE. start is ignored in this cycle.
- start is ignored in DELTA, ACCUM and DONE.
- All inputs must be held stable from the start edge until done. The block does not latch them.
- NaN, Inf and denormal handling is whatever the float cores do; no special casing apart from the ReLU ±0 rule.

## Timing
- Reset (rst=1 at an edge, in any state, including mid-pass):
  - State goes to IDLE.
  - grad_in, grad_weights, grad_bias all 0x00000000.
  - busy=0, done=0.
  - rst has priority over start.
- Let D = OUT_SIZE for ReLU/identity, or 2*OUT_SIZE for sigmoid/tanh. Let P = OUT_SIZE*IN_SIZE.
- If start is sampled at edge 0:
  - busy=1 after edges 1 .. D+P.
  - done=1 after edge D+P+1; busy=0 in that cycle.
  - Back in IDLE after edge D+P+2.
- The earliest next start is sampled at edge D+P+2.
- grad_bias[i] is final after its DELTA step. grad_weights[i][j] is final after its ACCUM step. grad_in is final only at done.
- Critical path: one multiplier feeding one adder, per cycle.

## Test plan
- ReLU, IN=2, OUT=2.
  - Stimulus: z=[1.0, -2.0]; g=[0.5, 3.0]; x=[2.0, 4.0]; W=[[1,2],[3,4]]; start at edge 0.
  - Required: grad_bias=[0x3F000000, 0]; grad_weights=[[0x3F800000, 0x40000000],[0, 0]]; grad_in=[0x3F000000, 0x3F800000]; done only after edge 7.
- Sigmoid, IN=1, OUT=1.
  - Stimulus: y=0.5, g=1.0, x=2.0, W=3.0.
  - Required: grad_bias=0x3E800000; grad_weights=0x3F000000; grad_in=0x3F400000; done after edge 4.
- Tanh, IN=1, OUT=1.
  - Stimulus: y=0.5, g=2.0, x=1.0, W=1.0.
  - Required: grad_bias=grad_weights=grad_in=0x3FC00000.
- ReLU with z=-0.0 (0x80000000), g=5.0.
  - Required: delta=+0; all grad_weights for that row +0; that row adds nothing to grad_in.
- Reset mid-ACCUM (rst at edge 4 of the case-1 run).
  - Required: next cycle all outputs 0 and busy=0; no done pulse.
  - A fresh start then gives the case-1 results.
- start held high through a whole pass.
  - Required: ignored while busy and in DONE.
  - A second pass is accepted at edge D+P+2; grad_in is not carried over from the first pass.
